shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Command-level controller for the 8-bit universal shift register (modes: 00 hold, 01 shift toward LSB with Sr into MSB, 10 shift toward MSB with Sl into LSB, 11 parallel load D).
- Accepts one command at a time over a start/busy/done handshake.
- Drives the register's S/Sr/Sl/D cycle by cycle to perform load, multi-bit shift, rotate, clear, and load-then-serialise operations.
- Sits between the control logic and the shift register; the register's Q feeds back in for rotates.

Parameters:
- WIDTH, 8, register width; must match the controlled shift register.
- CNTW, 4, shift-count width; must hold the value WIDTH.

Ports:
- CP  input  1  clock; rising edge active
- CR  input  1  asynchronous active-high reset
- start  input  1  command strobe; sampled only in IDLE
- op  input  3  command code: 000 NOP, 001 LOAD, 010 SHR, 011 SHL, 100 ROR, 101 ROL, 110 LDSHR, 111 CLEAR
- amt  input  CNTW  shift count; values above WIDTH clamp to WIDTH
- data  input  WIDTH  load value for LOAD/LDSHR
- fill  input  1  serial fill bit for SHR/SHL/LDSHR
- Q  input  WIDTH  current shift-register contents, fed back
- S  output  2  mode select to the register
- Sr  output  1  serial input at the MSB end, used in mode 01
- Sl  output  1  serial input at the LSB end, used in mode 10
- D  output  WIDTH  parallel load value to the register
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset:
  - CR high forces IDLE asynchronously.
  - Output values: S=00, Sr=0, Sl=0, D=0, busy=0, done=0.
  - Latched op, amt, data, fill and the counter are cleared.
  - Reset does not clear the shift register itself.
  - Reset mid-command aborts immediately; the register keeps its partial result.
- Command accept:
  - Acceptance happens in IDLE when start=1, at the rising edge of CP.
  - At acceptance, latch op, clamped amt (cnt), data and fill.
  - start while busy is ignored; nothing is queued.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE -> LOAD: op is LOAD, LDSHR or CLEAR.
  - IDLE -> SHIFT: op is SHR/SHL/ROR/ROL and cnt>0.
  - IDLE -> DONE: op is NOP, or a shift op with cnt=0.
  - LOAD -> SHIFT: op is LDSHR and cnt>0; otherwise LOAD -> DONE.
  - SHIFT: cnt decrements each cycle; when cnt=1, go to DONE.
  - DONE -> IDLE unconditionally.
- Outputs per state (combinational from state, latched values and Q):
  - IDLE and DONE: S=00.
  - LOAD: S=11; D=data_r (D=0 for CLEAR).
  - SHIFT, SHR/LDSHR: S=01, Sr=fill_r.
  - SHIFT, SHL: S=10, Sl=fill_r.
  - SHIFT, ROR: S=01, Sr=Q[0].
  - SHIFT, ROL: S=10, Sl=Q[WIDTH-1].
  - Sr and Sl are 0 whenever they are unused.
  - D holds data_r outside LOAD (don't-care to the register).
- done is high exactly in DONE; busy=1 in LOAD, SHIFT and DONE.
- Latency, with T = acceptance edge:
  - LOAD/CLEAR: LOAD during T+1, done during T+2.
  - Shift ops with N>0: SHIFT during T+1..T+N, done during T+N+1.
  - LDSHR with N>0: LOAD during T+1, SHIFT during T+2..T+N+1, done during T+N+2.
  - NOP, or N=0: done during T+1.
- Next accept: earliest in the cycle after done (back-to-back, no gap beyond DONE).
- Clamping: amt>=WIDTH gives exactly WIDTH shifts.
  - Rotate by WIDTH leaves Q unchanged.
  - Shift by WIDTH leaves Q all fill.

Test Plan:
- Reset mid-command: assert CR during SHIFT -> same cycle S=00, busy=0, done=0; Q frozen at its partial value.
- LOAD, data=8'hA5 -> S=11 for 1 cycle, Q=A5 after it; done one cycle later; busy high for 2 cycles.
- Shifts from Q=A5:
  - SHR amt=3, fill=1 -> 3 cycles of S=01, Q=F4.
  - SHL amt=2, fill=0 -> Q=94.
- Rotates:
  - ROR amt=1 from Q=81 -> Q=C0.
  - ROL amt=12 from Q=3C -> exactly 8 shift cycles, Q=3C.
- LDSHR data=8'h0F, amt=4, fill=0 -> LOAD then 4 shifts, Q=00; done at T+6.
- Edge cases:
  - NOP -> done at T+1.
  - SHL amt=0 -> done at T+1, S stays 00.
  - start asserted while busy -> ignored, no extra done.
  - CLEAR -> Q=00.

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer: command-level controller that drives an 8-bit universal shift register
// through load, shift, rotate, clear and load-then-serialise operations.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic             CP,
    input  logic             CR,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNTW-1:0]  amt,
    input  logic [WIDTH-1:0] data,
    input  logic             fill,
    input  logic [WIDTH-1:0] Q,
    output logic [1:0]       S,
    output logic             Sr,
    output logic             Sl,
    output logic [WIDTH-1:0] D,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;
    typedef enum logic [2:0] {
        OP_NOP, OP_LOAD, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_LDSHR, OP_CLEAR
    } op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             fill_q, fill_d;
    logic [CNTW-1:0]  amt_clamped;
    op_e              op_in;

    assign op_in       = op_e'(op);
    assign amt_clamped = (amt > CNTW'(WIDTH)) ? CNTW'(WIDTH) : amt;

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            cnt_q   <= '0;
            data_q  <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        fill_d  = fill_q;
        case (state_q)
            IDLE: if (start) begin
                op_d   = op_in;
                cnt_d  = amt_clamped;
                data_d = data;
                fill_d = fill;
                if (op_in == OP_LOAD || op_in == OP_LDSHR || op_in == OP_CLEAR)
                    state_d = LOAD;
                else if (op_in != OP_NOP && amt_clamped != '0)
                    state_d = SHIFT;
                else
                    state_d = DONE;
            end
            LOAD:  state_d = (op_q == OP_LDSHR && cnt_q != '0) ? SHIFT : DONE;
            SHIFT: begin
                cnt_d   = cnt_q - CNTW'(1);
                state_d = (cnt_q == CNTW'(1)) ? DONE : SHIFT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Rotates recirculate the bit leaving the far end of the live register.
    always_comb begin
        S    = 2'b00;
        Sr   = 1'b0;
        Sl   = 1'b0;
        D    = data_q;
        busy = state_q != IDLE;
        done = state_q == DONE;
        case (state_q)
            LOAD: begin
                S = 2'b11;
                D = (op_q == OP_CLEAR) ? '0 : data_q;
            end
            SHIFT: case (op_q)
                OP_SHL: begin
                    S  = 2'b10;
                    Sl = fill_q;
                end
                OP_ROR: begin
                    S  = 2'b01;
                    Sr = Q[0];
                end
                OP_ROL: begin
                    S  = 2'b10;
                    Sl = Q[WIDTH-1];
                end
                default: begin
                    S  = 2'b01;
                    Sr = fill_q;
                end
            endcase
            default: ;
        endcase
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: drives commands into shift_sequencer with a universal shift register
// attached, checking final contents, latency and handshake against a reference model.
module tb_shift_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] op = 3'd0;
    logic [3:0] amt = 4'd0;
    logic [7:0] data = 8'h00;
    logic       fill = 1'b0;
    logic [7:0] q = 8'h00;
    logic [1:0] s;
    logic       sr, sl, busy, done;
    logic [7:0] d;

    int checks = 0;
    int errors = 0;

    shift_sequencer dut (
        .CP(clk), .CR(rst), .start(start), .op(op), .amt(amt), .data(data),
        .fill(fill), .Q(q), .S(s), .Sr(sr), .Sl(sl), .D(d), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        case (s)
            2'b01: q <= {sr, q[7:1]};
            2'b10: q <= {q[6:0], sl};
            2'b11: q <= d;
            default: ;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int clampn(input int a);
        return (a > 8) ? 8 : a;
    endfunction

    function automatic int shr(input int v, input int n, input int f);
        return ((v >> n) | (f != 0 ? (32'hFF << (8 - n)) : 0)) & 32'hFF;
    endfunction

    function automatic int shl(input int v, input int n, input int f);
        return ((v << n) | (f != 0 ? (32'hFF >> (8 - n)) : 0)) & 32'hFF;
    endfunction

    function automatic int ref_q(input int o, input int a, input int dv, input int f, input int qv);
        int n = clampn(a);
        case (o)
            1: return dv;
            2: return shr(qv, n, f);
            3: return shl(qv, n, f);
            4: return ((qv >> n) | (qv << (8 - n))) & 32'hFF;
            5: return ((qv << n) | (qv >> (8 - n))) & 32'hFF;
            6: return shr(dv, n, f);
            7: return 0;
            default: return qv;
        endcase
    endfunction

    function automatic int ref_lat(input int o, input int a);
        int n = clampn(a);
        if (o == 1 || o == 7) return 2;
        if (o == 6) return n + 2;
        if (o == 0) return 1;
        return n + 1;
    endfunction

    function automatic int ref_shifts(input int o, input int a);
        return (o >= 2 && o <= 6) ? clampn(a) : 0;
    endfunction

    // Issue one command and observe the cycles until done.
    task automatic run_cmd(input int o, input int a, input int dv, input int f,
                           output int lat, output int busy_n, output int sh_n);
        @(negedge clk);
        start = 1'b1;
        op    = 3'(o);
        amt   = 4'(a);
        data  = 8'(dv);
        fill  = f[0];
        @(posedge clk);
        #1 start = 1'b0;
        lat    = 0;
        busy_n = 0;
        sh_n   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (busy) busy_n++;
            if (s == 2'b01 || s == 2'b10) sh_n++;
            if (done) break;
        end
    endtask

    task automatic do_cmd(input string name, input int o, input int a, input int dv, input int f);
        int lat, busy_n, sh_n, exp_q, exp_lat;
        exp_q   = ref_q(o, a, dv, f, int'(q));
        exp_lat = ref_lat(o, a);
        run_cmd(o, a, dv, f, lat, busy_n, sh_n);
        chk({name, " q"}, int'(q), exp_q);
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " busy cycles"}, busy_n, exp_lat);
        chk({name, " shift cycles"}, sh_n, ref_shifts(o, a));
    endtask

    typedef struct {
        string name;
        int    o;
        int    a;
        int    dv;
        int    f;
        int    exp_q;
        int    exp_lat;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int lat, busy_n, sh_n, dones, exp_q;
        vecs[0]  = '{"load a5",    1, 0,  'hA5, 0, 'hA5, 2};
        vecs[1]  = '{"shr3 f1",    2, 3,  0,    1, 'hF4, 4};
        vecs[2]  = '{"reload a5",  1, 0,  'hA5, 0, 'hA5, 2};
        vecs[3]  = '{"shl2 f0",    3, 2,  0,    0, 'h94, 3};
        vecs[4]  = '{"load 81",    1, 0,  'h81, 0, 'h81, 2};
        vecs[5]  = '{"ror1",       4, 1,  0,    0, 'hC0, 2};
        vecs[6]  = '{"load 3c",    1, 0,  'h3C, 0, 'h3C, 2};
        vecs[7]  = '{"rol12",      5, 12, 0,    0, 'h3C, 9};
        vecs[8]  = '{"ldshr 0f",   6, 4,  'h0F, 0, 'h00, 6};
        vecs[9]  = '{"nop",        0, 5,  'hFF, 1, 'h00, 1};
        vecs[10] = '{"load 5a",    1, 0,  'h5A, 0, 'h5A, 2};
        vecs[11] = '{"shl0",       3, 0,  0,    1, 'h5A, 1};
        vecs[12] = '{"shr15 f1",   2, 15, 0,    1, 'hFF, 9};

        repeat (2) @(posedge clk);
        #1 chk("reset outputs", {s, sr, sl, d, busy, done}, 0);
        @(negedge clk) rst = 1'b0;

        foreach (vecs[i]) begin
            run_cmd(vecs[i].o, vecs[i].a, vecs[i].dv, vecs[i].f, lat, busy_n, sh_n);
            chk({vecs[i].name, " q"}, int'(q), vecs[i].exp_q);
            chk({vecs[i].name, " latency"}, lat, vecs[i].exp_lat);
            chk({vecs[i].name, " busy cycles"}, busy_n, vecs[i].exp_lat);
        end

        do_cmd("clear", 7, 0, 'hFF, 1);
        chk("clear zero", int'(q), 0);

        // start pulsed while busy must be ignored.
        do_cmd("load c3", 1, 0, 'hC3, 0);
        exp_q = shr(int'(q), 4, 0);
        @(negedge clk);
        start = 1'b1; op = 3'd2; amt = 4'd4; fill = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 3'd1; data = 8'h00;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        repeat (10) @(negedge clk) if (done) dones++;
        chk("busy start done count", dones, 1);
        chk("busy start q", int'(q), exp_q);

        // Reset mid-shift aborts and freezes the partial result.
        do_cmd("load ff", 1, 0, 'hFF, 0);
        @(negedge clk);
        start = 1'b1; op = 3'd3; amt = 4'd8; fill = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("abort outputs", {s, busy, done}, 0);
        repeat (3) @(posedge clk);
        #1 chk("abort q frozen", int'(q), 'hF8);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 40; i++) begin
            int ro, ra, rd, rf;
            ro = int'($urandom_range(0, 7));
            ra = int'($urandom_range(0, 15));
            rd = int'($urandom_range(0, 255));
            rf = int'($urandom_range(0, 1));
            do_cmd($sformatf("rand%0d op%0d amt%0d", i, ro, ra), ro, ra, rd, rf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
